// File: rtl/alu_loader_pkg.sv
// Shared types for the ALU operand loader: FSM state encoding and selector width.
package alu_loader_pkg;

  localparam int unsigned SEL_W = 3;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    CAPTURE = 3'd3,
    SHOW    = 3'd4
  } loader_state_t;

endpackage

// File: rtl/alu_operand_loader_btn.sv
// Button conditioner: 2-flop synchronizer, optional debounce, rising-edge pulse.
// Debounce is compiled in with ALU_LOADER_DEBOUNCE_EN.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  localparam int unsigned HOLD = DEB_EN ? DEBOUNCE_CYCLES : 0;

  logic s1, s2, lvl, prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  if (HOLD > 0) begin : g_deb
    localparam int unsigned CW = $clog2(HOLD + 1);
    logic [CW-1:0] cnt;

    // Level flips only after s2 has disagreed with it for HOLD consecutive cycles.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(HOLD)) begin
        cnt <= '0;
        lvl <= s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end else begin : g_nodeb
    always_ff @(posedge clk) begin
      if (!rst_n) lvl <= 1'b0;
      else        lvl <= s2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= lvl;
  end

  assign pulse = lvl & ~prev;

endmodule

// File: rtl/alu_operand_loader.sv
// Sequential front end for the ALU: loads A, B and the operation one press at a
// time, then registers the ALU result. Optional debounce via ALU_LOADER_DEBOUNCE_EN.
module alu_operand_loader
  import alu_loader_pkg::*;
#(
  parameter int unsigned N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     sw,
  input  logic [SEL_W-1:0] sel_sw,
  input  logic             op_sw,
  input  logic             btn_load,
  input  logic             btn_clr,
  input  logic [N:0]       alu_out,
  output logic [N-1:0]     A,
  output logic [N-1:0]     B,
  output logic [SEL_W-1:0] selector,
  output logic             operacion,
  output logic             operands_valid,
  output logic [N:0]       result,
  output logic             result_valid,
  output logic [2:0]       state
);

  logic load_p, clr_p;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_load),
    .pulse (load_p)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clr),
    .pulse (clr_p)
  );

  loader_state_t cur_q, nxt;
  logic ld_a, ld_b, ld_op, cap, release_q;

  always_ff @(posedge clk) begin
    if (!rst_n) cur_q <= LOAD_A;
    else        cur_q <= nxt;
  end

  always_comb begin
    nxt       = cur_q;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_op     = 1'b0;
    cap       = 1'b0;
    release_q = 1'b0;
    if (clr_p) begin
      nxt = LOAD_A;
    end else begin
      unique case (cur_q)
        LOAD_A: if (load_p) begin
          ld_a = 1'b1;
          nxt  = LOAD_B;
        end
        LOAD_B: if (load_p) begin
          ld_b = 1'b1;
          nxt  = LOAD_OP;
        end
        LOAD_OP: if (load_p) begin
          ld_op = 1'b1;
          nxt   = CAPTURE;
        end
        CAPTURE: begin
          cap = 1'b1;
          nxt = SHOW;
        end
        SHOW: if (load_p) begin
          release_q = 1'b1;
          nxt       = LOAD_A;
        end
        default: nxt = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      A              <= '0;
      B              <= '0;
      selector       <= '0;
      operacion      <= 1'b0;
      operands_valid <= 1'b0;
      result         <= '0;
      result_valid   <= 1'b0;
    end else begin
      if (ld_a) A <= sw;
      if (ld_b) B <= sw;
      if (ld_op) begin
        selector       <= sel_sw;
        operacion      <= op_sw;
        operands_valid <= 1'b1;
      end
      if (cap) begin
        result       <= alu_out;
        result_valid <= 1'b1;
      end
      if (clr_p || release_q) begin
        operands_valid <= 1'b0;
        result_valid   <= 1'b0;
      end
    end
  end

  assign state = cur_q;

endmodule
